// File: rtl/keypad_pkg.sv
// Shared types, key map and small bit helpers for the keypad scan controller.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } scan_state_t;

  // Indexed [row][col]; row 3 carries the E/0/F/D keys.
  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  function automatic logic [1:0] enc4(input logic [3:0] v);
    if (v[0]) return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else return 2'd3;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider producing a one-cycle tick every 2^TICK_EXP clocks.
module scan_tick_gen #(
  parameter int unsigned TICK_EXP = 15
) (
  input  logic clk,
  input  logic nreset,
  output logic tick
);

  logic [TICK_EXP-1:0] r_cnt;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = &r_cnt;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: row drive, single-key debounce, release wait, valid/ready key output.
// Define KEYPAD_REPEAT_EN to add auto-repeat while a key stays held.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned TICK_EXP           = 15,
  parameter int unsigned DEBOUNCE_TICKS     = 50,
  parameter int unsigned RELEASE_TICKS      = 8,
  parameter int unsigned REPEAT_DELAY_TICKS = 200,
  parameter int unsigned REPEAT_RATE_TICKS  = 40
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [3:0] key_code,
  output logic       key_held,
  output logic       multi_err,
  output logic       drop
);

  localparam int unsigned DebW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int unsigned RelW = $clog2(RELEASE_TICKS + 1);
  localparam logic [DebW-1:0] DebMax = DebW'(DEBOUNCE_TICKS);
  localparam logic [RelW-1:0] RelMax = RelW'(RELEASE_TICKS);

  logic                w_tick;
  scan_state_t         r_state, w_state_d;
  logic [1:0]          r_row_idx, w_row_d;
  logic [1:0]          r_col_idx, w_col_d;
  logic [DebW-1:0]     r_cnt, w_cnt_d, w_cnt_inc;
  logic [RelW-1:0]     r_rcnt, w_rcnt_d, w_rcnt_inc;
  logic                r_key_valid, w_valid_d;
  logic [3:0]          r_key_code, w_code_d, w_code;
  logic                r_multi_err, r_drop, w_drop_d;
  logic                w_emit, w_multi;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RepMaxVal = (REPEAT_DELAY_TICKS > REPEAT_RATE_TICKS) ?
                                      REPEAT_DELAY_TICKS : REPEAT_RATE_TICKS;
  localparam int unsigned RepW = $clog2(RepMaxVal + 1);
  localparam logic [RepW-1:0] RepDelay = RepW'(REPEAT_DELAY_TICKS);
  localparam logic [RepW-1:0] RepRate  = RepW'(REPEAT_RATE_TICKS);
  localparam logic [RepW-1:0] RepSat   = RepW'(RepMaxVal);

  logic [RepW-1:0] r_rep_cnt, w_rep_d, w_rep_inc;
  logic            r_rep_armed, w_armed_d;

  assign w_rep_inc = (r_rep_cnt == RepSat) ? r_rep_cnt : r_rep_cnt + RepW'(1);
`endif

  scan_tick_gen #(
    .TICK_EXP(TICK_EXP)
  ) u_tick (
    .clk   (clk),
    .nreset(nreset),
    .tick  (w_tick)
  );

  assign w_cnt_inc  = (r_cnt == DebMax) ? r_cnt : r_cnt + DebW'(1);
  assign w_rcnt_inc = (r_rcnt == RelMax) ? r_rcnt : r_rcnt + RelW'(1);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state     <= SCAN;
      r_row_idx   <= 2'd0;
      r_col_idx   <= 2'd0;
      r_cnt       <= '0;
      r_rcnt      <= '0;
      r_key_valid <= 1'b0;
      r_key_code  <= 4'h0;
      r_multi_err <= 1'b0;
      r_drop      <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_d;
      r_row_idx   <= w_row_d;
      r_col_idx   <= w_col_d;
      r_cnt       <= w_cnt_d;
      r_rcnt      <= w_rcnt_d;
      r_key_valid <= w_valid_d;
      r_key_code  <= w_code_d;
      r_multi_err <= w_multi;
      r_drop      <= w_drop_d;
`ifdef KEYPAD_REPEAT_EN
      r_rep_cnt   <= w_rep_d;
      r_rep_armed <= w_armed_d;
`endif
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_row_d   = r_row_idx;
    w_col_d   = r_col_idx;
    w_cnt_d   = r_cnt;
    w_rcnt_d  = r_rcnt;
    w_emit    = 1'b0;
    w_multi   = 1'b0;
    w_code    = KEYMAP[r_row_idx][r_col_idx];
`ifdef KEYPAD_REPEAT_EN
    w_rep_d   = r_rep_cnt;
    w_armed_d = r_rep_armed;
`endif
    if (w_tick) begin
      unique case (r_state)
        SCAN: begin
          if (col == 4'b0000) begin
            w_row_d = r_row_idx + 2'd1;
          end else if (popcount4(col) == 3'd1) begin
            w_col_d = enc4(col);
            w_code  = KEYMAP[r_row_idx][enc4(col)];
            if (DEBOUNCE_TICKS == 1) begin
              w_emit    = 1'b1;
              w_state_d = HELD;
              w_rcnt_d  = '0;
            end else begin
              w_cnt_d   = DebW'(1);
              w_state_d = DEBOUNCE;
            end
          end else begin
            w_multi = 1'b1;
            w_row_d = r_row_idx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (col == onehot4(r_col_idx)) begin
            w_cnt_d = w_cnt_inc;
            if (w_cnt_inc == DebMax) begin
              w_emit    = 1'b1;
              w_state_d = HELD;
              w_rcnt_d  = '0;
            end
          end else begin
            w_state_d = SCAN;
            w_row_d   = r_row_idx + 2'd1;
            w_cnt_d   = '0;
          end
        end
        HELD: begin
          if (!col[r_col_idx]) begin
            w_rcnt_d = w_rcnt_inc;
            if (w_rcnt_inc == RelMax) begin
              w_state_d = SCAN;
              w_row_d   = r_row_idx + 2'd1;
              w_rcnt_d  = '0;
              w_cnt_d   = '0;
            end
          end else begin
            w_rcnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
            w_rep_d = w_rep_inc;
            if (!r_rep_armed && (w_rep_inc == RepDelay)) begin
              w_emit    = 1'b1;
              w_armed_d = 1'b1;
              w_rep_d   = '0;
            end else if (r_rep_armed && (w_rep_inc == RepRate)) begin
              w_emit  = 1'b1;
              w_rep_d = '0;
            end
`endif
          end
        end
        default: begin
          w_state_d = SCAN;
        end
      endcase
    end
`ifdef KEYPAD_REPEAT_EN
    if ((w_state_d == HELD) && (r_state != HELD)) begin
      w_rep_d   = '0;
      w_armed_d = 1'b0;
    end
`endif

    // A fresh emit always wins over the handshake; drop only if the old code was not taken.
    w_valid_d = r_key_valid;
    w_code_d  = r_key_code;
    w_drop_d  = 1'b0;
    if (w_emit) begin
      w_valid_d = 1'b1;
      w_code_d  = w_code;
      w_drop_d  = r_key_valid & ~key_ready;
    end else if (r_key_valid && key_ready) begin
      w_valid_d = 1'b0;
    end
  end

  always_comb begin
    row       = onehot4(r_row_idx);
    key_held  = (r_state != SCAN);
    key_valid = r_key_valid;
    key_code  = r_key_code;
    multi_err = r_multi_err;
    drop      = r_drop;
  end

endmodule
